// File: rtl/concat_stream_n.sv
// Per-channel FIFOs feeding an in-order frame serialiser: ch0..ch(N-1) frames, MSB-first beats.
// First beat 2 cycles after a word enters the current channel's empty FIFO; output stalls on !i_out_ready.

module concat_stream_n_fifo #(
   parameter int WIDTH = 97,
   parameter int DEPTH = 256
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_empty,
   output logic             o_ready
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;
   logic             r_ready;
   logic             w_wr;
   logic [PW:0]      w_count_nxt;

   assign w_wr        = i_wr_en && r_ready;
   assign w_count_nxt = r_count + {{PW{1'b0}}, w_wr} - {{PW{1'b0}}, i_rd_en};
   assign o_rd_data   = r_mem[r_rd_ptr];
   assign o_empty     = (r_count == '0);
   assign o_ready     = r_ready;

   // Ready is registered from the next count so a pop at full only reopens the following cycle.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ready  <= 1'b0;
      end else begin
         if (w_wr)    r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         r_ready <= (w_count_nxt != (PW+1)'(DEPTH));
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end
endmodule

module concat_stream_n #(
   parameter int NUM_CH    = 3,
   parameter int IN_WIDTH  = 96,
   parameter int OUT_WIDTH = 8,
   parameter int DEPTH     = 256
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic [NUM_CH*IN_WIDTH-1:0]  i_in_data,
   input  logic [NUM_CH-1:0]           i_in_valid,
   input  logic [NUM_CH-1:0]           i_in_last,
   output logic [NUM_CH-1:0]           o_in_ready,
   output logic [OUT_WIDTH-1:0]        o_out_data,
   output logic                        o_out_valid,
   output logic                        o_out_last,
   output logic [$clog2(NUM_CH)-1:0]   o_out_chan,
   input  logic                        i_out_ready
);
   localparam int RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int CW    = $clog2(NUM_CH);
   localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
   localparam logic [CW-1:0] CH_MAX    = CW'(NUM_CH - 1);
   localparam bit PASS_THRU = (RATIO == 1);

   typedef enum logic {S_LOAD, S_SHIFT} state_t;

   logic [IN_WIDTH:0]    w_q [NUM_CH];
   logic [NUM_CH-1:0]    w_empty;
   logic [NUM_CH-1:0]    w_pop_vec;
   logic                 w_xfer;
   logic                 w_final;
   logic                 w_pop;
   logic [CW-1:0]        w_ch_inc;
   logic [CW-1:0]        w_next_ch;
   logic [IN_WIDTH:0]    w_word;
   logic [BW-1:0]        w_beat_inc;

   state_t               r_state;
   logic [CW-1:0]        r_cur_ch;
   logic [BW-1:0]        r_beat;
   logic [IN_WIDTH-1:0]  r_shift;
   logic                 r_word_last;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      concat_stream_n_fifo #(.WIDTH(IN_WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
         .i_clock   (i_clock),
         .i_reset   (i_reset),
         .i_wr_en   (i_in_valid[c]),
         .i_wr_data ({i_in_last[c], i_in_data[c*IN_WIDTH +: IN_WIDTH]}),
         .i_rd_en   (w_pop_vec[c]),
         .o_rd_data (w_q[c]),
         .o_empty   (w_empty[c]),
         .o_ready   (o_in_ready[c])
      );
   end

   // A finished word either reloads from the same channel or advances; both can pop in the same cycle.
   always_comb begin
      w_xfer     = o_out_valid && i_out_ready;
      w_final    = w_xfer && (r_beat == LAST_BEAT);
      w_beat_inc = r_beat + 1'b1;
      w_ch_inc   = (r_cur_ch == CH_MAX) ? '0 : r_cur_ch + 1'b1;
      w_next_ch  = (w_final && r_word_last) ? w_ch_inc : r_cur_ch;
      w_pop      = ((r_state == S_LOAD) || w_final) && !w_empty[w_next_ch];
      w_word     = w_q[w_next_ch];
      w_pop_vec  = '0;
      if (w_pop) w_pop_vec[w_next_ch] = 1'b1;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= S_LOAD;
         r_cur_ch    <= '0;
         r_beat      <= '0;
         r_shift     <= '0;
         r_word_last <= 1'b0;
         o_out_data  <= '0;
         o_out_valid <= 1'b0;
         o_out_last  <= 1'b0;
         o_out_chan  <= '0;
      end else if (w_pop) begin
         r_state     <= S_SHIFT;
         r_cur_ch    <= w_next_ch;
         r_beat      <= '0;
         r_shift     <= w_word[IN_WIDTH-1:0] << OUT_WIDTH;
         r_word_last <= w_word[IN_WIDTH];
         o_out_data  <= w_word[IN_WIDTH-1 -: OUT_WIDTH];
         o_out_valid <= 1'b1;
         o_out_chan  <= w_next_ch;
         o_out_last  <= PASS_THRU && w_word[IN_WIDTH] && (w_next_ch == CH_MAX);
      end else if (w_final) begin
         r_state     <= S_LOAD;
         r_cur_ch    <= w_next_ch;
         o_out_valid <= 1'b0;
         o_out_last  <= 1'b0;
      end else if (w_xfer) begin
         r_beat     <= w_beat_inc;
         r_shift    <= r_shift << OUT_WIDTH;
         o_out_data <= r_shift[IN_WIDTH-1 -: OUT_WIDTH];
         o_out_last <= (w_beat_inc == LAST_BEAT) && r_word_last && (r_cur_ch == CH_MAX);
      end
   end
endmodule

// File: tb/tb_concat_stream_n.sv
// Scoreboard bench for concat_stream_n: directed frames, expected beats queued at stimulus time.
module tb_concat_stream_n;
   localparam int N  = 3;
   localparam int IW = 96;
   localparam int OW = 8;
   localparam int D  = 256;

   localparam logic [IW-1:0] W0 = 96'h0102030405060708090A0B0C;
   localparam logic [IW-1:0] W1 = 96'h1112131415161718191A1B1C;
   localparam logic [IW-1:0] W2 = 96'h2122232425262728292A2B2C;
   localparam logic [IW-1:0] WA = 96'h3132333435363738393A3B3C;
   localparam logic [IW-1:0] WB = 96'h4142434445464748494A4B4C;

   typedef struct packed {
      logic [OW-1:0] d;
      logic [1:0]    ch;
      logic          l;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [N*IW-1:0]   in_data;
   logic [N-1:0]      in_valid;
   logic [N-1:0]      in_last;
   logic [N-1:0]      in_ready;
   logic [OW-1:0]     out_data;
   logic              out_valid;
   logic              out_last;
   logic [1:0]        out_chan;
   logic              out_ready;

   logic [IW-1:0]     dat_c [N];
   logic              vld_c [N];
   logic              lst_c [N];

   beat_t exp_q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int xfers = 0;
   int first_cyc = -1;
   int last_cyc = -1;
   int t5_acc = 0;

   for (genvar c = 0; c < N; c++) begin : g_in
      assign in_data[c*IW +: IW] = dat_c[c];
      assign in_valid[c]         = vld_c[c];
      assign in_last[c]          = lst_c[c];
   end

   concat_stream_n #(.NUM_CH(N), .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(D)) dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_in_data   (in_data),
      .i_in_valid  (in_valid),
      .i_in_last   (in_last),
      .o_in_ready  (in_ready),
      .o_out_data  (out_data),
      .o_out_valid (out_valid),
      .o_out_last  (out_last),
      .o_out_chan  (out_chan),
      .i_out_ready (out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #2000000;
      $display("FAIL watchdog: sim time limit reached, queue=%0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [IW-1:0] w5(input int i);
      logic [IW-1:0] r;
      for (int k = 0; k < 12; k++) r[IW-1-8*k -: 8] = 8'(i * 3 + k);
      return r;
   endfunction

   task automatic push_word(input int ch, input logic [IW-1:0] w, input logic lastw);
      logic [IW-1:0] t;
      beat_t b;
      t = w;
      for (int k = 0; k < 12; k++) begin
         b.d  = t[IW-1 -: 8];
         b.ch = 2'(ch);
         b.l  = lastw && (ch == N-1) && (k == 11);
         exp_q.push_back(b);
         t = t << 8;
      end
   endtask

   task automatic send(input int c, input logic [IW-1:0] d, input logic l);
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      dat_c[c] = d;
      lst_c[c] = l;
      vld_c[c] = 1'b1;
      while (!acc && n < 2000) begin
         @(negedge clk);
         acc = in_ready[c];
         @(posedge clk);
         n++;
      end
      #1;
      vld_c[c] = 1'b0;
      lst_c[c] = 1'b0;
      if (!acc) chk("send_timeout", 64'(n), 64'(0));
   endtask

   task automatic wait_drain(input int bound);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      repeat (20) @(posedge clk);
      #1;
      chk("drain", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic mark();
      xfers = 0;
      first_cyc = -1;
      last_cyc = -1;
   endtask

   task automatic push_t1();
      push_word(0, W0, 1'b1);
      push_word(1, W1, 1'b1);
      push_word(2, W2, 1'b1);
   endtask

   // Monitor: pops the scoreboard on every transfer and checks hold stability during stalls.
   beat_t prev;
   bit    stalled = 1'b0;
   always @(negedge clk) begin
      beat_t cur;
      beat_t e;
      cur = {out_data, out_chan, out_last};
      if (rst) begin
         exp_q.delete();
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            chk("hold_vld", 64'(out_valid), 64'(1));
            chk("hold_dat", 64'(cur), 64'(prev));
         end
         if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL extra_beat: got %0h want none (cycle %0d)", cur, cyc);
            end else begin
               e = exp_q.pop_front();
               total--;
               chk("beat", 64'(cur), 64'(e));
            end
            xfers++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
         stalled = out_valid && !out_ready;
         prev = cur;
      end
   end

   initial begin
      int n;
      int cnt;
      for (int c = 0; c < N; c++) begin
         vld_c[c] = 1'b0;
         lst_c[c] = 1'b0;
         dat_c[c] = '0;
      end
      rst = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_data", 64'(out_data), 64'(0));
      chk("rst_last", 64'(out_last), 64'(0));
      chk("rst_chan", 64'(out_chan), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rdy_still_low", 64'(in_ready), 64'(0));
      @(negedge clk);
      chk("rst_rdy_high", 64'(in_ready), 64'(3'b111));
      @(posedge clk);
      #1;

      // Test 1: one word per channel, free-flowing output
      mark();
      push_t1();
      send(0, W0, 1'b1);
      send(1, W1, 1'b1);
      send(2, W2, 1'b1);
      wait_drain(300);
      chk("t1_count", 64'(xfers), 64'(36));
      chk("t1_gapless", 64'(last_cyc - first_cyc + 1), 64'(36));

      // Test 2: ch0 arrives last; nothing may overtake it
      mark();
      push_t1();
      send(2, W2, 1'b1);
      send(1, W1, 1'b1);
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      @(posedge clk);
      #1;
      chk("t2_early", 64'(cnt), 64'(0));
      send(0, W0, 1'b1);
      @(negedge clk);
      chk("t2_lat_t1", 64'(out_valid), 64'(0));
      @(negedge clk);
      chk("t2_lat_t2", 64'(out_valid), 64'(1));
      chk("t2_first", 64'(out_data), 64'(8'h01));
      @(posedge clk);
      #1;
      wait_drain(300);
      chk("t2_count", 64'(xfers), 64'(36));
      chk("t2_gapless", 64'(last_cyc - first_cyc + 1), 64'(36));

      // Test 3: three-word ch0 frame
      mark();
      push_word(0, WA, 1'b0);
      push_word(0, WB, 1'b0);
      push_word(0, W0, 1'b1);
      push_word(1, W1, 1'b1);
      push_word(2, W2, 1'b1);
      send(0, WA, 1'b0);
      send(0, WB, 1'b0);
      send(0, W0, 1'b1);
      send(1, W1, 1'b1);
      send(2, W2, 1'b1);
      wait_drain(400);
      chk("t3_count", 64'(xfers), 64'(60));
      chk("t3_gapless", 64'(last_cyc - first_cyc + 1), 64'(60));

      // Test 4: toggling downstream ready
      mark();
      out_ready = 1'b0;
      push_t1();
      send(0, W0, 1'b1);
      send(1, W1, 1'b1);
      send(2, W2, 1'b1);
      n = 0;
      while (exp_q.size() > 0 && n < 500) begin
         out_ready = (n % 2 == 0);
         @(posedge clk);
         #1;
         n++;
      end
      out_ready = 1'b1;
      wait_drain(300);
      chk("t4_count", 64'(xfers), 64'(36));

      // Test 5: ch1 fills while ch0 is empty
      mark();
      push_word(0, W0, 1'b1);
      for (int i = 0; i < D + 4; i++) push_word(1, w5(i), (i == D + 3));
      push_word(2, W2, 1'b1);
      t5_acc = 0;
      fork
         begin
            int k;
            bit a;
            k = 0;
            dat_c[1] = w5(0);
            lst_c[1] = 1'b0;
            vld_c[1] = 1'b1;
            while (t5_acc < D + 4 && k < 20000) begin
               @(negedge clk);
               a = in_ready[1];
               @(posedge clk);
               if (a) begin
                  t5_acc++;
                  #1;
                  dat_c[1] = w5(t5_acc);
                  lst_c[1] = (t5_acc == D + 3);
               end
               k++;
            end
            #1;
            vld_c[1] = 1'b0;
            lst_c[1] = 1'b0;
         end
         begin
            int k;
            int c0;
            k = 0;
            while (t5_acc < D && k < 1000) begin
               @(negedge clk);
               k++;
            end
            repeat (10) @(negedge clk);
            chk("t5_full_cnt", 64'(t5_acc), 64'(D));
            chk("t5_rdy_low", 64'(in_ready[1]), 64'(0));
            @(posedge clk);
            #1;
            send(0, W0, 1'b1);
            c0 = 0;
            k = 0;
            while (c0 < 12 && k < 200) begin
               @(negedge clk);
               if (out_valid && out_ready && out_chan == 2'd0) c0++;
               k++;
            end
            chk("t5_rdy_before_pop", 64'(in_ready[1]), 64'(0));
            @(negedge clk);
            chk("t5_rdy_after_pop", 64'(in_ready[1]), 64'(1));
            send(2, W2, 1'b1);
         end
      join
      chk("t5_total_acc", 64'(t5_acc), 64'(D + 4));
      wait_drain(6000);
      chk("t5_count", 64'(xfers), 64'(12 + (D + 4) * 12 + 12));

      // Test 6: reset mid-frame, then replay
      mark();
      push_t1();
      send(0, W0, 1'b1);
      send(1, W1, 1'b1);
      send(2, W2, 1'b1);
      n = 0;
      while (xfers < 5 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t6_five_beats", 64'(xfers), 64'(5));
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_valid_in_rst", 64'(out_valid), 64'(0));
      @(negedge clk);
      chk("t6_valid_after", 64'(out_valid), 64'(0));
      chk("t6_ready_after", 64'(in_ready), 64'(3'b111));
      @(posedge clk);
      #1;
      mark();
      push_t1();
      send(0, W0, 1'b1);
      send(1, W1, 1'b1);
      send(2, W2, 1'b1);
      wait_drain(300);
      chk("t6_count", 64'(xfers), 64'(36));
      chk("t6_gapless", 64'(last_cyc - first_cyc + 1), 64'(36));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
